uart8_rx_fifo: RTL and testbench
================================

Name: uart8_rx_fifo

Overview:
Downstream stage of the 8-bit UART receiver. Runs in the receiver's 16x-oversample clock domain. Captures each received byte on the receiver's done pulse and queues it in a first-word-fall-through FIFO. Presents the bytes to the host through a valid/ready handshake, with overflow and error tracking.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2
PTR_W, $clog2(DEPTH), pointer index width (derived, not overridden)

Ports:
clk  input  1  rx sampling clock, same clock that drives the receiver
rst  input  1  asynchronous, active-high reset
rx_done  input  1  receiver done; held high about 16 clk per byte
rx_err  input  1  receiver err level
rx_data  input  8  receiver parallel output; valid while rx_done is high
flush  input  1  synchronous clear of FIFO contents and overflow flag
rd_ready  input  1  host accepts the head byte this cycle
rd_valid  output  1  FIFO non-empty; head byte on rd_data
rd_data  output  8  head byte (fall-through)
count  output  PTR_W+1  number of entries stored, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky; a byte was dropped because the FIFO was full
err_count  output  8  framing-error event counter (only with UART_RX_ERR_COUNT_EN)

Behaviour:
- Reset (async assert, sync-safe deassert): pointers=0, count=0, rd_valid=0, rd_data=0, full=0, overflow=0, err_count=0, edge registers=0.
- Push detect: done_q registers rx_done. push = rx_done & !done_q, so exactly one push per done pulse regardless of its length. rx_data is written in the same cycle as the push. Latency: byte visible on rd_data and rd_valid=1 on the cycle after the push edge.
- Pop: pop = rd_valid & rd_ready. The head advances on that clk edge. The next entry, if any, appears on the next cycle. rd_ready while empty is ignored.
- Pointers: wr_ptr and rd_ptr are PTR_W+1 bits, with the MSB as the wrap bit.
  - empty when the pointers are equal.
  - full when the indices are equal and the MSBs differ.
  - Natural modular wrap; no special casing at DEPTH-1.
- count = wr_ptr - rd_ptr, computed modulo 2^(PTR_W+1).
- Push while full and no pop: byte dropped, pointers unchanged, overflow set to 1 (sticky).
- Push while full with simultaneous pop: slot frees, byte accepted, overflow not set, count stays DEPTH.
- Push and pop while non-empty and non-full: both happen, count unchanged.
- Push and pop while empty: pop is not possible (rd_valid=0); push only, count becomes 1.
- flush: pointers=0 and overflow=0 next cycle. A push edge in the same cycle as flush is discarded. err_count is not affected. done_q still updates, so a done pulse already high at flush release does not re-push.
- rd_data when empty: holds the last driven value; the bench must not check it.
- Reset mid-transfer: everything clears immediately. If rx_done is high when rst deasserts, done_q=0 makes that pulse push once. This is acceptable: the receiver's out is still valid while done is high.
- No state machine beyond the pointer/flag registers. Storage is a register array of DEPTH x 8, written only on accepted push.

Optional Feature:
UART_RX_ERR_COUNT_EN
- Defined: err_q registers rx_err. On rx_err & !err_q, err_count increments and saturates at 255. flush does not clear it; only rst does.
- Undefined: err_q and the counter are not built, and err_count is tied to 8'd0. The port stays present so the interface is fixed.

Decomposition:
- Shared package/header (alongside the UART state defines): constant UART_DATA_W=8 and constant ERR_COUNT_W=8.
- One natural sub-module, uart_edge_rise: a registered rising-edge detector (clk, rst, in -> pulse). It is instantiated for rx_done, and for rx_err when UART_RX_ERR_COUNT_EN is defined.
- The FIFO core stays inline.

Test Plan:
1. Three done pulses of 16 clk each with rx_data 8'hA5, 8'h3C, 8'hFF, rd_ready=0 -> count=3. With rd_ready held at 1, rd_data yields A5, 3C, FF on consecutive cycles, then rd_valid=0.
2. DEPTH=16: push 17 bytes 0x00..0x10 with no pops -> full=1 after 16 pushes; overflow=1 after the 17th. Reading returns 0x00..0x0F; 0x10 is absent.
3. FIFO full, rd_ready=1 held on the cycle of a push edge with data 8'h77 -> overflow stays 0, count stays 16, and 8'h77 is read out last.
4. Wrap: push and pop 40 bytes (i mod 256) in a streaming pattern -> order preserved, count never exceeds 2, pointers wrap correctly.
5. Four bytes queued plus overflow=1, assert flush for one cycle during an rx_done rising edge -> count=0, rd_valid=0, overflow=0 next cycle, and the concurrent byte is discarded.
6. UART_RX_ERR_COUNT_EN defined:
   - 300 rx_err rising edges -> err_count=255.
   - flush -> still 255.
   - rst mid-sequence -> 0 immediately.
   - Undefined build -> err_count=0 throughout.

Source files
------------

// File: rtl/uart8_rx_fifo_pkg.sv
// Shared constants for the 8-bit UART receive path.
// Holds the receiver state encodings and the data and error-counter widths.
package uart8_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;
  localparam int ERR_COUNT_W = 8;

  localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = '1;

  // Receiver state encodings, shared with the upstream bit-sampling FSM
  localparam logic [1:0] UART_ST_IDLE  = 2'd0;
  localparam logic [1:0] UART_ST_START = 2'd1;
  localparam logic [1:0] UART_ST_DATA  = 2'd2;
  localparam logic [1:0] UART_ST_STOP  = 2'd3;

endpackage

// File: rtl/uart8_rx_fifo_edge_rise.sv
// Registered rising-edge detector.
// The pulse is combinational from the live input, so it is high in the first
// cycle the input is high, and stays high for exactly one cycle.
module uart_edge_rise
  import uart8_rx_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  // Remember the previous input level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart8_rx_fifo.sv
// UART receive byte FIFO (first-word-fall-through) with overflow tracking.
// One byte is pushed per rising edge of rx_done; the host drains bytes over
// a valid/ready handshake.
// Optional feature: define UART_RX_ERR_COUNT_EN to build the saturating
// framing-error event counter on err_count (tied to zero otherwise).
module uart8_rx_fifo
  import uart8_rx_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_done,
  input  logic                   rx_err,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   flush,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [PTR_W:0]         count,
  output logic                   full,
  output logic                   overflow,
  output logic [ERR_COUNT_W-1:0] err_count
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d;
  logic [UART_DATA_W-1:0] head_q, head_d;
  logic                   done_rise;
  logic                   empty, push, pop, accept;
  logic [PTR_W-1:0]       wr_idx, rd_idx_d;

  uart_edge_rise u_done_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (rx_done),
    .pulse_o (done_rise)
  );

  assign wr_idx   = wr_ptr_q[PTR_W-1:0];
  assign rd_idx_d = rd_ptr_d[PTR_W-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A push edge coinciding with flush is discarded; a full FIFO only accepts
  // when a pop frees the head slot in the same cycle.
  assign push   = done_rise & ~flush;
  assign pop    = ~empty & rd_ready & ~flush;
  assign accept = push & (~full | pop);

  // Next pointers, sticky overflow and the registered fall-through head byte
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, accept};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    ovf_d    = ovf_q | (push & full & ~pop);
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end
    // The head is refreshed whenever the FIFO will be non-empty; a byte being
    // written into the next head slot is forwarded straight from rx_data.
    if (wr_ptr_d != rd_ptr_d) begin
      if (accept && (wr_idx == rd_idx_d)) head_d = rx_data;
      else                                head_d = mem_q[rd_idx_d];
    end
  end

  // Control and head registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  // Byte storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_idx] <= rx_data;
  end

  assign rd_valid = ~empty;
  assign rd_data  = head_q;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overflow = ovf_q;

`ifdef UART_RX_ERR_COUNT_EN
  logic                   err_rise;
  logic [ERR_COUNT_W-1:0] err_cnt_q, err_cnt_d;

  uart_edge_rise u_err_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (rx_err),
    .pulse_o (err_rise)
  );

  // Saturating error-event count; flush leaves it alone
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_rise && (err_cnt_q != ERR_COUNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  logic unused_rx_err;
  assign unused_rx_err = rx_err;
  assign err_count     = '0;
`endif

endmodule

// File: tb/tb_uart8_rx_fifo.sv
// Directed testbench for uart8_rx_fifo (DEPTH = 16).
module tb_uart8_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic       rx_err;
  logic [7:0] rx_data;
  logic       flush;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] err_count;

  int n_chk = 0;
  int n_bad = 0;

  logic       mon_en = 1'b0;
  int         rcv_n  = 0;
  int         max_cnt = 0;
  logic [7:0] rcv [64];

  uart8_rx_fifo #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .flush     (flush),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One done pulse of 'hi' cycles followed by two idle cycles
  task automatic send(input logic [7:0] d, input int hi);
    rx_data = d;
    rx_done = 1'b1;
    repeat (hi) tick();
    rx_done = 1'b0;
    tick();
    tick();
  endtask

  // Stream monitor: records every popped byte and the peak occupancy
  always @(negedge clk) begin
    if (mon_en) begin
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (rd_valid && rd_ready && rcv_n < 64) begin
        rcv[rcv_n] = rd_data;
        rcv_n++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    flush = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Test 1: three long done pulses, then drain back-to-back
    send(8'hA5, 16);
    send(8'h3C, 16);
    send(8'hFF, 16);
    @(negedge clk);
    chk("t1_count", 32'(count), 32'd3);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    @(negedge clk); chk("t1_rd0", 32'(rd_data), 32'hA5);
    @(negedge clk); chk("t1_rd1", 32'(rd_data), 32'h3C);
    @(negedge clk); chk("t1_rd2", 32'(rd_data), 32'hFF);
    @(negedge clk); chk("t1_empty", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rd_ready = 1'b0;

    // Test 2: 17 pushes into 16 entries
    for (int i = 0; i < 16; i++) send(8'(i), 4);
    @(negedge clk);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count16", 32'(count), 32'd16);
    chk("t2_ovf0", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    send(8'h10, 4);
    @(negedge clk);
    chk("t2_ovf1", 32'(overflow), 32'd1);
    chk("t2_count_hold", 32'(count), 32'd16);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("t2_rd%0d", i), 32'(rd_data), 32'(i));
    end
    @(negedge clk); chk("t2_empty", 32'(rd_valid), 32'd0);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t2_flush_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;

    // Test 3: push while full with a simultaneous pop
    for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 4);
    rx_data  = 8'h77;
    rx_done  = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("t3_count", 32'(count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_full", 32'(full), 32'd1);
    @(posedge clk); #1;
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("t3_rd%0d", i), 32'(rd_data), 32'(8'h21 + i));
    end
    @(negedge clk); chk("t3_last", 32'(rd_data), 32'h77);
    @(negedge clk); chk("t3_empty", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;

    // Test 4: streaming 40 bytes through the wrapping pointers
    rcv_n = 0; max_cnt = 0; mon_en = 1'b1;
    for (int i = 0; i < 40; i++) send(8'(i), 1);
    tick();
    mon_en = 1'b0;
    rd_ready = 1'b0;
    chk("t4_n", 32'(rcv_n), 32'd40);
    for (int i = 0; i < 40; i++) chk($sformatf("t4_rd%0d", i), 32'(rcv[i]), 32'(i));
    chk("t4_maxcnt_le2", 32'(max_cnt <= 2), 32'd1);
    @(negedge clk); chk("t4_empty", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;

    // Test 5: flush with four queued bytes, overflow set and a concurrent push
    for (int i = 0; i < 17; i++) send(8'(8'h40 + i), 2);
    rd_ready = 1'b1;
    repeat (12) tick();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("t5_count4", 32'(count), 32'd4);
    chk("t5_ovf1", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    rx_data = 8'hEE;
    rx_done = 1'b1;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_valid0", 32'(rd_valid), 32'd0);
    chk("t5_ovf0", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    repeat (3) tick();
    rx_done = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_no_repush", 32'(count), 32'd0);
    @(posedge clk); #1;

    // Test 6: error event counter
`ifdef UART_RX_ERR_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      rx_err = 1'b1; tick();
      rx_err = 1'b0; tick();
    end
    @(negedge clk); chk("t6_sat", 32'(err_count), 32'd255);
    @(posedge clk); #1;
    flush = 1'b1; tick(); flush = 1'b0;
    @(negedge clk); chk("t6_flush_keep", 32'(err_count), 32'd255);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rst", 32'(err_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      rx_err = 1'b1; tick();
      rx_err = 1'b0; tick();
    end
    @(negedge clk); chk("t6_count3", 32'(err_count), 32'd3);
`else
    for (int i = 0; i < 5; i++) begin
      rx_err = 1'b1; tick();
      @(negedge clk); chk($sformatf("t6_off%0d", i), 32'(err_count), 32'd0);
      @(posedge clk); #1;
      rx_err = 1'b0; tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
